oc_reset_sequencer: RTL and testbench

Synthesizable reset conditioner that consumes a raw board or simulation reset. It produces a set of ordered, synchronously released block resets in one clock domain.
- Assertion of the incoming reset is asynchronous.
- Deassertion is synchronized, held for a minimum time, then released stage by stage.
- Each stage waits for a per-stage readiness input, such as PLL lock or memory calibration.
- It sits directly downstream of the reset source and upstream of all core logic. It also supports a software-requested re-reset.

---
 rtl/oc_reset_sequencer.sv | 117 +++++++++++
 tb/tb_oc_reset_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/oc_reset_sequencer.sv
// Reset conditioner: async assert, synchronized release, then ordered per-stage
// deassertion gated by readiness inputs, with soft re-reset and stall detection.
module oc_reset_sequencer #(
    parameter int unsigned NumStages        = 3,
    parameter int unsigned SyncCycles       = 2,
    parameter int unsigned MinResetCycles   = 16,
    parameter int unsigned StageDelayCycles = 8,
    parameter int unsigned TimeoutCycles    = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 soft_reset_req,
    input  logic [NumStages-1:0] stage_ready,
    output logic [NumStages-1:0] stage_reset,
    output logic                 reset_done,
    output logic                 soft_reset_ack,
    output logic                 stall_timeout
);

    localparam int unsigned CntMax = (MinResetCycles > StageDelayCycles) ? MinResetCycles
                                                                         : StageDelayCycles;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned IdxW   = (NumStages > 1) ? $clog2(NumStages) : 1;
    localparam int unsigned WaitW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_DONE
    } state_t;

    state_t                state;
    logic [CntW-1:0]       cnt;
    logic [IdxW-1:0]       idx;
    logic [WaitW-1:0]      wait_cnt;
    logic [SyncCycles-1:0] sync_q;
    logic                  run;

    // Release synchronizer: clears instantly, fills with ones after reset rises.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncCycles-2:0], 1'b1};
        end
    end

    assign run = sync_q[SyncCycles-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ST_ASSERT;
            cnt            <= '0;
            idx            <= '0;
            wait_cnt       <= '0;
            stage_reset    <= '1;
            reset_done     <= 1'b0;
            soft_reset_ack <= 1'b0;
            stall_timeout  <= 1'b0;
        end else if (run) begin
            soft_reset_ack <= 1'b0;
            // A soft request outranks any release scheduled on the same edge.
            if (soft_reset_req && (state != ST_ASSERT)) begin
                state          <= ST_ASSERT;
                cnt            <= '0;
                idx            <= '0;
                wait_cnt       <= '0;
                stage_reset    <= '1;
                reset_done     <= 1'b0;
                soft_reset_ack <= 1'b1;
                stall_timeout  <= 1'b0;
            end else begin
                case (state)
                    ST_ASSERT: begin
                        if (cnt >= CntW'(MinResetCycles - 1)) begin
                            state    <= ST_RELEASE;
                            cnt      <= '0;
                            idx      <= '0;
                            wait_cnt <= '0;
                        end else begin
                            cnt <= cnt + CntW'(1);
                        end
                    end
                    ST_RELEASE: begin
                        if (cnt < CntW'(StageDelayCycles - 1)) begin
                            cnt <= cnt + CntW'(1);
                        end else if (stage_ready[idx]) begin
                            stage_reset[idx] <= 1'b0;
                            cnt              <= '0;
                            wait_cnt         <= '0;
                            if (idx == IdxW'(NumStages - 1)) begin
                                state <= ST_DONE;
                            end else begin
                                idx <= idx + IdxW'(1);
                            end
                        end else begin
                            // Delay elapsed but stage not ready: count the stall, keep waiting.
                            if (wait_cnt != WaitW'(TimeoutCycles)) begin
                                wait_cnt <= wait_cnt + WaitW'(1);
                            end
                            if ((TimeoutCycles != 0) && (wait_cnt == WaitW'(TimeoutCycles - 1))) begin
                                stall_timeout <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        reset_done <= 1'b1;
                    end
                    default: begin
                        state <= ST_ASSERT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oc_reset_sequencer.sv
// Directed bench for oc_reset_sequencer: nominal release timing, readiness hold,
// stall timeout, soft re-reset, async mid-sequence reset and soft-request corner cases.
module tb_oc_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       soft_reset_req;
    logic [2:0] stage_ready;
    logic [2:0] stage_reset;
    logic       reset_done;
    logic       soft_reset_ack;
    logic       stall_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int ecnt  = 0;

    always #5 clock = ~clock;

    oc_reset_sequencer #(
        .NumStages       (3),
        .SyncCycles      (2),
        .MinResetCycles  (16),
        .StageDelayCycles(8),
        .TimeoutCycles   (20)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .soft_reset_req(soft_reset_req),
        .stage_ready   (stage_ready),
        .stage_reset   (stage_reset),
        .reset_done    (reset_done),
        .soft_reset_ack(soft_reset_ack),
        .stall_timeout (stall_timeout)
    );

    // Advance one posedge and sample just after it; ecnt numbers edges since reset rose.
    task automatic adv();
        @(posedge clock);
        ecnt++;
        #1;
    endtask

    // Pulse reset low and release it at a negedge so the next posedge is edge 1.
    task automatic start_seq();
        reset          = 1'b0;
        soft_reset_req = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        ecnt  = 0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        soft_reset_req = 1'b0;
        stage_ready    = 3'b111;
        #3;
        reset = 1'b0;
        #1;
        n_cmp++; if (stage_reset !== 3'b111) begin n_bad++; $display("FAIL reset stage_reset: got %b want 111", stage_reset); end
        n_cmp++; if (reset_done !== 1'b0) begin n_bad++; $display("FAIL reset reset_done: got %b want 0", reset_done); end
        n_cmp++; if (soft_reset_ack !== 1'b0) begin n_bad++; $display("FAIL reset soft_reset_ack: got %b want 0", soft_reset_ack); end
        n_cmp++; if (stall_timeout !== 1'b0) begin n_bad++; $display("FAIL reset stall_timeout: got %b want 0", stall_timeout); end
        repeat (3) adv();
        n_cmp++; if (stage_reset !== 3'b111) begin n_bad++; $display("FAIL reset_held stage_reset: got %b want 111", stage_reset); end
    endtask

    task automatic test_nominal();
        logic [2:0] exp_sr;
        stage_ready = 3'b111;
        start_seq();
        for (int e = 1; e <= 45; e++) begin
            adv();
            exp_sr = {ecnt < 42, ecnt < 34, ecnt < 26};
            n_cmp++; if (stage_reset !== exp_sr) begin n_bad++; $display("FAIL nominal stage_reset edge %0d: got %b want %b", ecnt, stage_reset, exp_sr); end
            n_cmp++; if (reset_done !== (ecnt >= 43)) begin n_bad++; $display("FAIL nominal reset_done edge %0d: got %b", ecnt, reset_done); end
        end
    endtask

    task automatic test_ready_hold();
        logic [2:0] exp_sr;
        stage_ready = 3'b101;
        start_seq();
        for (int e = 1; e <= 60; e++) begin
            adv();
            exp_sr = {ecnt < 58, ecnt < 50, ecnt < 26};
            n_cmp++; if (stage_reset !== exp_sr) begin n_bad++; $display("FAIL hold stage_reset edge %0d: got %b want %b", ecnt, stage_reset, exp_sr); end
            n_cmp++; if (reset_done !== (ecnt >= 59)) begin n_bad++; $display("FAIL hold reset_done edge %0d: got %b", ecnt, reset_done); end
            n_cmp++; if (stall_timeout !== 1'b0) begin n_bad++; $display("FAIL hold stall_timeout edge %0d: got %b want 0", ecnt, stall_timeout); end
            if (ecnt == 49) stage_ready = 3'b111;
        end
    endtask

    // Runs directly after test_ready_hold, with the sequencer sitting in DONE.
    task automatic test_soft_in_done();
        logic [2:0] exp_sr;
        while (ecnt < 99) begin
            adv();
            n_cmp++; if (stage_reset !== 3'b000 || reset_done !== 1'b1) begin n_bad++; $display("FAIL done_idle edge %0d: got sr=%b done=%b want 000/1", ecnt, stage_reset, reset_done); end
        end
        soft_reset_req = 1'b1;
        adv();
        soft_reset_req = 1'b0;
        n_cmp++; if (stage_reset !== 3'b111) begin n_bad++; $display("FAIL soft_done stage_reset edge 100: got %b want 111", stage_reset); end
        n_cmp++; if (reset_done !== 1'b0) begin n_bad++; $display("FAIL soft_done reset_done edge 100: got %b want 0", reset_done); end
        n_cmp++; if (soft_reset_ack !== 1'b1) begin n_bad++; $display("FAIL soft_done ack edge 100: got %b want 1", soft_reset_ack); end
        while (ecnt < 143) begin
            adv();
            exp_sr = {ecnt < 140, ecnt < 132, ecnt < 124};
            n_cmp++; if (stage_reset !== exp_sr) begin n_bad++; $display("FAIL soft_done stage_reset edge %0d: got %b want %b", ecnt, stage_reset, exp_sr); end
            n_cmp++; if (reset_done !== (ecnt >= 141)) begin n_bad++; $display("FAIL soft_done reset_done edge %0d: got %b", ecnt, reset_done); end
            n_cmp++; if (soft_reset_ack !== 1'b0) begin n_bad++; $display("FAIL soft_done ack edge %0d: got %b want 0", ecnt, soft_reset_ack); end
        end
    endtask

    task automatic test_timeout();
        stage_ready = 3'b110;
        start_seq();
        for (int e = 1; e <= 60; e++) begin
            adv();
            n_cmp++; if (stage_reset !== 3'b111) begin n_bad++; $display("FAIL timeout stage_reset edge %0d: got %b want 111", ecnt, stage_reset); end
            if (ecnt <= 43) begin
                n_cmp++; if (stall_timeout !== 1'b0) begin n_bad++; $display("FAIL timeout early_flag edge %0d: got %b want 0", ecnt, stall_timeout); end
            end
            if (ecnt >= 46) begin
                n_cmp++; if (stall_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout flag edge %0d: got %b want 1", ecnt, stall_timeout); end
            end
        end
        soft_reset_req = 1'b1;
        stage_ready    = 3'b111;
        adv();
        soft_reset_req = 1'b0;
        n_cmp++; if (soft_reset_ack !== 1'b1) begin n_bad++; $display("FAIL timeout_soft ack edge %0d: got %b want 1", ecnt, soft_reset_ack); end
        n_cmp++; if (stall_timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_soft flag edge %0d: got %b want 0", ecnt, stall_timeout); end
        while (ecnt < 86) begin
            adv();
            n_cmp++; if (stage_reset !== {2'b11, ecnt < 85}) begin n_bad++; $display("FAIL timeout_resume stage_reset edge %0d: got %b", ecnt, stage_reset); end
            n_cmp++; if (stall_timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_resume flag edge %0d: got %b want 0", ecnt, stall_timeout); end
        end
    endtask

    task automatic test_async_mid();
        logic [2:0] exp_sr;
        stage_ready = 3'b111;
        start_seq();
        while (ecnt < 29) adv();
        n_cmp++; if (stage_reset !== 3'b110) begin n_bad++; $display("FAIL async pre stage_reset: got %b want 110", stage_reset); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (stage_reset !== 3'b111) begin n_bad++; $display("FAIL async immediate stage_reset: got %b want 111", stage_reset); end
        n_cmp++; if (reset_done !== 1'b0) begin n_bad++; $display("FAIL async immediate reset_done: got %b want 0", reset_done); end
        soft_reset_req = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #1;
            n_cmp++; if (soft_reset_ack !== 1'b0 || stage_reset !== 3'b111) begin n_bad++; $display("FAIL async held: got ack=%b sr=%b want 0/111", soft_reset_ack, stage_reset); end
        end
        soft_reset_req = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        ecnt  = 0;
        for (int e = 1; e <= 44; e++) begin
            adv();
            exp_sr = {ecnt < 42, ecnt < 34, ecnt < 26};
            n_cmp++; if (stage_reset !== exp_sr) begin n_bad++; $display("FAIL async restart stage_reset edge %0d: got %b want %b", ecnt, stage_reset, exp_sr); end
            n_cmp++; if (reset_done !== (ecnt >= 43)) begin n_bad++; $display("FAIL async restart reset_done edge %0d: got %b", ecnt, reset_done); end
            n_cmp++; if (soft_reset_ack !== 1'b0) begin n_bad++; $display("FAIL async restart ack edge %0d: got %b want 0", ecnt, soft_reset_ack); end
        end
    endtask

    task automatic test_soft_corner();
        logic [2:0] exp_sr;
        stage_ready = 3'b111;
        start_seq();
        while (ecnt < 33) begin
            adv();
            exp_sr = {2'b11, ecnt < 26};
            n_cmp++; if (stage_reset !== exp_sr) begin n_bad++; $display("FAIL corner stage_reset edge %0d: got %b want %b", ecnt, stage_reset, exp_sr); end
            n_cmp++; if (soft_reset_ack !== 1'b0) begin n_bad++; $display("FAIL corner assert_ack edge %0d: got %b want 0", ecnt, soft_reset_ack); end
            if (ecnt == 9)  soft_reset_req = 1'b1;
            if (ecnt == 10) soft_reset_req = 1'b0;
        end
        soft_reset_req = 1'b1;
        adv();
        soft_reset_req = 1'b0;
        n_cmp++; if (soft_reset_ack !== 1'b1) begin n_bad++; $display("FAIL corner coincide ack edge 34: got %b want 1", soft_reset_ack); end
        n_cmp++; if (stage_reset !== 3'b111) begin n_bad++; $display("FAIL corner coincide stage_reset edge 34: got %b want 111", stage_reset); end
        while (ecnt < 76) begin
            adv();
            exp_sr = {ecnt < 74, ecnt < 66, ecnt < 58};
            n_cmp++; if (stage_reset !== exp_sr) begin n_bad++; $display("FAIL corner reseq stage_reset edge %0d: got %b want %b", ecnt, stage_reset, exp_sr); end
            n_cmp++; if (reset_done !== (ecnt >= 75)) begin n_bad++; $display("FAIL corner reseq reset_done edge %0d: got %b", ecnt, reset_done); end
            n_cmp++; if (soft_reset_ack !== 1'b0) begin n_bad++; $display("FAIL corner reseq ack edge %0d: got %b want 0", ecnt, soft_reset_ack); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_ready_hold();
        test_soft_in_done();
        test_timeout();
        test_async_mid();
        test_soft_corner();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
